// File: rtl/cell_sweep_pkg.sv
// Shared definitions for the cell truth-table sweeper.
//   - sweep FSM state encoding (legacy-compatible constants)
//   - default golden table for an AOI221 cell
//   - helpers for record / error-counter widths
package cell_sweep_pkg;

    typedef logic [1:0] sweep_state_t;

    localparam sweep_state_t StIdle  = 2'd0;
    localparam sweep_state_t StApply = 2'd1;
    localparam sweep_state_t StLog   = 2'd2;
    localparam sweep_state_t StDone  = 2'd3;

    // AOI221, vector bits {A,B1,B2,C1,C2}: Y = !(A | B1&B2 | C1&C2)
    localparam logic [31:0] Aoi221Truth = 32'h0000_0777;

    // Record is {vec, obs, exp}.
    function automatic int unsigned rec_width(input int unsigned n_in);
        return n_in + 2;
    endfunction

    // One extra bit so a count of 2^n_in mismatches fits.
    function automatic int unsigned err_width(input int unsigned n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle timer for the sweeper.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clear       force the count back to zero (wins over enable)
//   en          advance the count
//   term        high while the count equals SETTLE-1
module sweep_settle_timer #(
    parameter int unsigned SETTLE = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic term
);

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] TermVal = CntW'(SETTLE - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign term = (cnt_q == TermVal);

    // Stop at the terminal value so the count can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !term) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cell_sweep_checker.sv
// Exhaustive truth-table sweeper for a combinational cell.
// Drives every input vector in ascending order, holds it SETTLE cycles, samples the cell
// output, compares it with TRUTH and streams one {vec, obs, exp} record per vector over
// a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin a sweep (ignored while busy)
//   stop_on_fail        latched at start; end sweep after the first mismatch record
//   vec_o / dut_i       vector to the cell / cell output
//   busy, done, pass    sweep status; pass valid with done
//   err_cnt             mismatches this sweep
//   first_fail_*        first mismatching vector
//   rec_*               result record stream
module cell_sweep_checker
    import cell_sweep_pkg::*;
#(
    parameter int unsigned N_IN = 5,
    parameter int unsigned SETTLE = 10,
    parameter logic [(2**N_IN)-1:0] TRUTH = Aoi221Truth
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop_on_fail,
    output logic [N_IN-1:0] vec_o,
    input  logic            dut_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic [N_IN-1:0] rec_vec,
    output logic            rec_obs,
    output logic            rec_exp
);

    localparam int unsigned RecW = rec_width(N_IN);
    localparam int unsigned ErrW = err_width(N_IN);
    localparam logic [N_IN-1:0] LastVec = '1;

    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [ErrW-1:0] err_q, err_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            sof_q, sof_d;
    logic [RecW-1:0] rec_q, rec_d;

    logic tmr_clear;
    logic tmr_term;
    logic mismatch;
    logic rec_mismatch;

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tmr_clear),
        .en    (state_q == StApply),
        .term  (tmr_term)
    );

    assign mismatch     = (dut_i != TRUTH[vec_q]);
    assign rec_mismatch = (rec_q[1] != rec_q[0]);

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvec_d   = ffvec_q;
        sof_d     = sof_q;
        rec_d     = rec_q;
        tmr_clear = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                // DONE restarts directly; first_fail_vec is kept, only its valid clears.
                if (start) begin
                    vec_d     = '0;
                    tmr_clear = 1'b1;
                    err_d     = '0;
                    ffv_d     = 1'b0;
                    sof_d     = stop_on_fail;
                    state_d   = StApply;
                end
            end
            StApply: begin
                if (tmr_term) begin
                    rec_d = {vec_q, dut_i, TRUTH[vec_q]};
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
                    end
                    state_d = StLog;
                end
            end
            StLog: begin
                if (rec_ready) begin
                    if ((vec_q == LastVec) || (sof_q && rec_mismatch)) begin
                        state_d = StDone;
                    end else begin
                        vec_d     = vec_q + 1'b1;
                        tmr_clear = 1'b1;
                        state_d   = StApply;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            sof_q   <= 1'b0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            sof_q   <= sof_d;
            rec_q   <= rec_d;
        end
    end

    // All outputs come straight from registers.
    assign vec_o            = vec_q;
    assign busy             = (state_q == StApply) || (state_q == StLog);
    assign done             = (state_q == StDone);
    assign pass             = done && (err_q == '0);
    assign err_cnt          = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
    assign rec_valid        = (state_q == StLog);
    assign rec_vec          = rec_q[RecW-1:2];
    assign rec_obs          = rec_q[1];
    assign rec_exp          = rec_q[0];

endmodule

// File: tb/tb_cell_sweep_checker.sv
module tb_cell_sweep_checker;

    localparam int N_IN   = 5;
    localparam int SETTLE = 10;
    localparam int NVEC   = 32;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop_on_fail;
    logic [4:0] vec_o;
    logic       dut_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_cnt;
    logic       first_fail_valid;
    logic [4:0] first_fail_vec;
    logic       rec_valid;
    logic       rec_ready;
    logic [4:0] rec_vec;
    logic       rec_obs;
    logic       rec_exp;

    // 0 = correct AOI221, 1 = stuck-at-0, 2 = stuck-at-1
    int dut_mode;

    cell_sweep_checker #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .stop_on_fail     (stop_on_fail),
        .vec_o            (vec_o),
        .dut_i            (dut_i),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_cnt          (err_cnt),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
        .rec_valid        (rec_valid),
        .rec_ready        (rec_ready),
        .rec_vec          (rec_vec),
        .rec_obs          (rec_obs),
        .rec_exp          (rec_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Golden AOI221 from its boolean equation, bits {A,B1,B2,C1,C2}.
    function automatic logic aoi221(input logic [4:0] v);
        return !(v[4] | (v[3] & v[2]) | (v[1] & v[0]));
    endfunction

    function automatic logic cell_val(input int mode, input logic [4:0] v);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return aoi221(v);
    endfunction

    assign dut_i = cell_val(dut_mode, vec_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0] v;
        logic       o;
        logic       e;
    } rec_t;

    rec_t exp_q[$];
    int   exp_err;
    logic exp_ffv;
    logic [4:0] exp_ffvec;
    int   recs;
    rec_t first_rec;
    rec_t last_rec;
    int   k_start;

    // Expected record stream for a whole sweep, straight from the sweep rules.
    task automatic build_model(input int mode, input logic sof);
        rec_t r;
        exp_q.delete();
        exp_err = 0;
        exp_ffv = 1'b0;
        exp_ffvec = '0;
        for (int v = 0; v < NVEC; v++) begin
            r.v = 5'(v);
            r.o = cell_val(mode, 5'(v));
            r.e = aoi221(5'(v));
            exp_q.push_back(r);
            if (r.o != r.e) begin
                exp_err++;
                if (!exp_ffv) begin
                    exp_ffv = 1'b1;
                    exp_ffvec = 5'(v);
                end
                if (sof) break;
            end
        end
    endtask

    // Record scoreboard and hold-stability check.
    logic       prev_hold = 1'b0;
    logic [4:0] prev_vec;
    logic       prev_obs;
    logic       prev_exp;
    logic [4:0] prev_vo;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                chk("hold_rec_vec", 32'(rec_vec), 32'(prev_vec));
                chk("hold_rec_obs", 32'(rec_obs), 32'(prev_obs));
                chk("hold_rec_exp", 32'(rec_exp), 32'(prev_exp));
                chk("hold_vec_o", 32'(vec_o), 32'(prev_vo));
                chk("hold_valid", 32'(rec_valid), 32'd1);
            end
            if (rec_valid) chk("valid_busy", 32'(busy), 32'd1);
            if (rec_valid && rec_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_record", 32'(recs), 32'(-1));
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    chk("rec_vec", 32'(rec_vec), 32'(r.v));
                    chk("rec_obs", 32'(rec_obs), 32'(r.o));
                    chk("rec_exp", 32'(rec_exp), 32'(r.e));
                    chk("rec_vec_o", 32'(vec_o), 32'(r.v));
                end
                if (recs == 0) begin
                    first_rec.v = rec_vec; first_rec.o = rec_obs; first_rec.e = rec_exp;
                end
                last_rec.v = rec_vec; last_rec.o = rec_obs; last_rec.e = rec_exp;
                recs++;
            end
            prev_hold = rec_valid && !rec_ready;
        end else begin
            prev_hold = 1'b0;
        end
        prev_vec = rec_vec;
        prev_obs = rec_obs;
        prev_exp = rec_exp;
        prev_vo  = vec_o;
    end

    task automatic do_start(input int mode, input logic sof);
        dut_mode = mode;
        build_model(mode, sof);
        recs = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        stop_on_fail = sof;
        @(posedge clk);
        #1;
        start = 1'b0;
        k_start = cyc;
    endtask

    task automatic wait_done(input int hold_vec, input int hold_len, output int lat);
        bit held;
        bit ok;
        held = 0;
        ok = 0;
        lat = -1;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1;
                break;
            end
            if (hold_len > 0 && !held && rec_valid && rec_vec == 5'(hold_vec)) begin
                rec_ready = 1'b0;
                for (int i = 0; i < hold_len; i++) begin
                    @(posedge clk);
                    #1;
                    chk("bp_valid", 32'(rec_valid), 32'd1);
                    chk("bp_rec_vec", 32'(rec_vec), 32'(hold_vec));
                    chk("bp_vec_o", 32'(vec_o), 32'(hold_vec));
                end
                rec_ready = 1'b1;
                held = 1;
            end
        end
        if (ok) lat = cyc - k_start;
        else chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_end(input string tag, input int lat, input int exp_lat, input int exp_recs);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_records"}, 32'(recs), 32'(exp_recs));
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
        chk({tag, "_ffv"}, 32'(first_fail_valid), 32'(exp_ffv));
        if (exp_ffv) chk({tag, "_ffvec"}, 32'(first_fail_vec), 32'(exp_ffvec));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_vec_o"}, 32'(vec_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_ffv"}, 32'(first_fail_valid), 32'd0);
        chk({tag, "_ffvec"}, 32'(first_fail_vec), 32'd0);
        chk({tag, "_rec_valid"}, 32'(rec_valid), 32'd0);
        chk({tag, "_rec_vec"}, 32'(rec_vec), 32'd0);
        chk({tag, "_rec_obs"}, 32'(rec_obs), 32'd0);
        chk({tag, "_rec_exp"}, 32'(rec_exp), 32'd0);
    endtask

    initial begin
        int lat;
        int ones;
        int snap;
        bit found;

        rst_n = 1'b0;
        start = 1'b0;
        stop_on_fail = 1'b0;
        rec_ready = 1'b1;
        dut_mode = 0;
        recs = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Pin the golden model itself.
        ones = 0;
        for (int v = 0; v < NVEC; v++) ones += int'(aoi221(5'(v)));
        chk("model_ones", 32'(ones), 32'd9);
        chk("model_v0", 32'(aoi221(5'd0)), 32'd1);
        chk("model_v3", 32'(aoi221(5'd3)), 32'd0);

        // Correct cell, no backpressure.
        do_start(0, 1'b0);
        wait_done(0, 0, lat);
        check_end("good", lat, 352, 32);
        chk("good_pass_lit", 32'(pass), 32'd1);

        // Stuck-at-0, full sweep.
        do_start(1, 1'b0);
        wait_done(0, 0, lat);
        check_end("sa0", lat, 352, 32);
        chk("sa0_err_lit", 32'(err_cnt), 32'd9);
        chk("sa0_ffvec_lit", 32'(first_fail_vec), 32'd0);
        chk("sa0_rec0_obs", 32'(first_rec.o), 32'd0);
        chk("sa0_rec0_exp", 32'(first_rec.e), 32'd1);

        // Start from DONE clears status immediately.
        do_start(0, 1'b0);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_err", 32'(err_cnt), 32'd0);
        chk("restart_ffv", 32'(first_fail_valid), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_vec", 32'(vec_o), 32'd0);
        wait_done(0, 0, lat);
        check_end("restart", lat, 352, 32);

        // Stuck-at-1 with stop on first failure.
        do_start(2, 1'b1);
        wait_done(0, 0, lat);
        check_end("sa1", lat, 44, 4);
        chk("sa1_err_lit", 32'(err_cnt), 32'd1);
        chk("sa1_ffvec_lit", 32'(first_fail_vec), 32'd3);
        chk("sa1_last_vec", 32'(last_rec.v), 32'd3);
        chk("sa1_last_exp", 32'(last_rec.e), 32'd0);

        // Backpressure: 5 ready-low cycles at vector 7.
        do_start(0, 1'b0);
        wait_done(7, 5, lat);
        check_end("bp", lat, 357, 32);

        // Start pulsed while busy is ignored.
        do_start(0, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_novec0", 32'(vec_o != 5'd0), 32'd1);
        wait_done(0, 0, lat);
        check_end("busystart", lat, 352, 32);

        // Reset during vector 12 APPLY.
        do_start(0, 1'b0);
        found = 0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (vec_o == 5'd12 && busy && !rec_valid) begin
                found = 1;
                break;
            end
        end
        chk("reach_vec12", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        rst_n = 1'b1;
        exp_q.delete();
        snap = recs;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_recs", 32'(recs), 32'(snap));
        chk("midrst_idle", 32'(busy), 32'd0);
        do_start(0, 1'b0);
        chk("after_rst_vec0", 32'(vec_o), 32'd0);
        wait_done(0, 0, lat);
        check_end("afterrst", lat, 352, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
